// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch path: datapath widths, reset vector,
// and the {pc, instr} entry carried through the fetch queue.
package rv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} words; the head is always held in e0 so the
// consumer sees registered outputs. Push and pop may coincide; flush beats push.
module fetch_queue
  import rv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) e0_d = entry_i;
          else                 e1_d = entry_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Head leaves, new word appended behind whatever remains.
          if (count_q == 2'd1) begin
            e0_d = entry_i;
          end else begin
            e0_d = e1_q;
            e1_d = entry_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = e0_q;
  assign count_o = count_q;

  push_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && !flush_i && (count_q == 2'd2)));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle synchronous instruction ROM: owns the fetch PC, issues
// reads only when the returned word is guaranteed a queue slot, and squashes on redirect.
module imem_fetch_ctrl
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned Q_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_re,
  output logic [31:0] mem_a,
  input  logic [31:0] mem_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam logic [2:0] QDepth = 3'(Q_DEPTH);

  logic [31:0]  fpc_q, fpc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;

  logic [31:0]  redirect_aligned;
  logic [31:0]  issue_pc;
  logic         issue;
  logic         push;
  logic         pop;
  logic [2:0]   occupancy;
  logic [1:0]   q_count;
  fetch_entry_t q_head;
  fetch_entry_t q_entry;

  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    redirect_aligned = {redirect_pc[31:2], 2'b00};
    out_valid        = (q_count != 2'd0) & ~redirect_valid;
    pop              = out_valid & out_ready;
    // A squashed in-flight word is dropped rather than pushed.
    push             = inflight_q & ~redirect_valid;
    // Words still owed to the queue after this edge, counting the read in flight.
    occupancy        = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, pop};

    if (redirect_valid) begin
      issue    = fetch_en;
      issue_pc = redirect_aligned;
    end else begin
      issue    = fetch_en & (occupancy < QDepth);
      issue_pc = fpc_q;
    end

    if (issue)               fpc_d = issue_pc + 32'd4;
    else if (redirect_valid) fpc_d = redirect_aligned;
    else                     fpc_d = fpc_q;

    inflight_d    = issue;
    inflight_pc_d = issue ? issue_pc : inflight_pc_q;

    // Gate the combinational outputs so they drop the moment reset asserts.
    mem_re = rst_n & issue;
    mem_a  = rst_n ? {2'b00, issue_pc[31:2]} : 32'd0;

    q_entry = '{pc: inflight_pc_q, instr: mem_rd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue u_fetch_queue (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .entry_i (q_entry),
    .head_o  (q_head),
    .count_o (q_count)
  );

  assign out_instr = q_head.instr;
  assign out_pc    = q_head.pc;

endmodule
